// File: rtl/piano_key_responder_pkg.sv
// Shared constants, state type and elaboration-time FCW helpers for the piano key responder.
package piano_key_responder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  localparam logic [7:0] KEY_STOP     = 8'h23;
  localparam logic [7:0] KEY_UP       = 8'h2B;
  localparam logic [7:0] KEY_DOWN     = 8'h2D;
  localparam logic [7:0] ECHO_UNKNOWN = 8'h3F;

  localparam int NUM_NOTES = 13;

  // Chromatic C4..C5 in centi-Hz, indexed in keyboard order z s x d c v g b h n j m ,
  function automatic int note_centi_hz(input int idx);
    case (idx)
      0:       return 26163;
      1:       return 27718;
      2:       return 29366;
      3:       return 31113;
      4:       return 32963;
      5:       return 34923;
      6:       return 36999;
      7:       return 39200;
      8:       return 41530;
      9:       return 44000;
      10:      return 46616;
      11:      return 49388;
      default: return 52325;
    endcase
  endfunction

  // round(centi/100 * 2^fcw_width / sample_freq), half up, in 64-bit integer math
  function automatic logic [63:0] calc_fcw(input int centi, input int sample_freq,
                                           input int fcw_width);
    logic [63:0] num;
    logic [63:0] den;
    num = (64'(centi) << fcw_width) + 64'(sample_freq) * 64'd50;
    den = 64'(sample_freq) * 64'd100;
    return num / den;
  endfunction

endpackage

// File: rtl/piano_key_responder_if.sv
// UART rx/tx ready/valid ports plus the NCO control outputs of the key responder.
interface piano_key_responder_if #(
  parameter int FCW_WIDTH = 24
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [FCW_WIDTH-1:0] fcw;
  logic                 note_en;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid, fcw, note_en
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid, fcw, note_en
  );
endinterface

// File: rtl/piano_key_responder_note_lut.sv
// Combinational ASCII key -> {hit, FCW} lookup; the FCW table is built at elaboration.
module piano_note_lut
  import piano_key_responder_pkg::*;
#(
  parameter int SAMPLE_FREQ = 60_000,
  parameter int FCW_WIDTH   = 24
) (
  input  logic [7:0]           key_i,
  output logic                 hit_o,
  output logic [FCW_WIDTH-1:0] fcw_o
);

  logic [FCW_WIDTH-1:0] fcw_tab [NUM_NOTES];
  logic [3:0]           idx;

  for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_tab
    localparam logic [63:0] FULL = calc_fcw(note_centi_hz(gi), SAMPLE_FREQ, FCW_WIDTH);
    assign fcw_tab[gi] = FULL[FCW_WIDTH-1:0];
  end

  always_comb begin
    hit_o = 1'b1;
    idx   = 4'd0;
    case (key_i)
      8'h7A:   idx = 4'd0;   // z  C4
      8'h73:   idx = 4'd1;
      8'h78:   idx = 4'd2;
      8'h64:   idx = 4'd3;
      8'h63:   idx = 4'd4;
      8'h76:   idx = 4'd5;
      8'h67:   idx = 4'd6;
      8'h62:   idx = 4'd7;
      8'h68:   idx = 4'd8;
      8'h6E:   idx = 4'd9;   // n  A4
      8'h6A:   idx = 4'd10;
      8'h6D:   idx = 4'd11;
      8'h2C:   idx = 4'd12;  // ,  C5
      default: hit_o = 1'b0;
    endcase
  end

  always_comb begin
    fcw_o = '0;
    if (hit_o) begin
      case (idx)
        4'd0:    fcw_o = fcw_tab[0];
        4'd1:    fcw_o = fcw_tab[1];
        4'd2:    fcw_o = fcw_tab[2];
        4'd3:    fcw_o = fcw_tab[3];
        4'd4:    fcw_o = fcw_tab[4];
        4'd5:    fcw_o = fcw_tab[5];
        4'd6:    fcw_o = fcw_tab[6];
        4'd7:    fcw_o = fcw_tab[7];
        4'd8:    fcw_o = fcw_tab[8];
        4'd9:    fcw_o = fcw_tab[9];
        4'd10:   fcw_o = fcw_tab[10];
        4'd11:   fcw_o = fcw_tab[11];
        default: fcw_o = fcw_tab[12];
      endcase
    end
  end

endmodule

// File: rtl/piano_key_responder.sv
// UART key stream -> gated NCO frequency word, with a single-entry echo of every accepted byte.
module piano_key_responder
  import piano_key_responder_pkg::*;
#(
  parameter int SAMPLE_FREQ   = 60_000,
  parameter int FCW_WIDTH     = 24,
  parameter int LEN_WIDTH     = 24,
  parameter int NOTE_LEN_INIT = 12_500_000
) (
  input  logic                 clk,
  input  logic                 reset,
  piano_key_responder_if.slave bus
);

  state_e               state_q;
  logic [LEN_WIDTH-1:0] counter_q;
  logic [FCW_WIDTH-1:0] fcw_q;
  logic [LEN_WIDTH-1:0] note_len_q, note_len_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_data_q, tx_data_d;

  logic                 rx_ready;
  logic                 accept;
  logic                 key_hit;
  logic [FCW_WIDTH-1:0] key_fcw;
  logic                 is_stop, is_up, is_down;
  logic [LEN_WIDTH-1:0] len_half;

  piano_note_lut #(
    .SAMPLE_FREQ(SAMPLE_FREQ),
    .FCW_WIDTH  (FCW_WIDTH)
  ) u_lut (
    .key_i(bus.rx_data),
    .hit_o(key_hit),
    .fcw_o(key_fcw)
  );

  // Only one echo may be outstanding, so the input stalls while it waits
  assign rx_ready = !reset && !tx_valid_q;
  assign accept   = bus.rx_valid && rx_ready;
  assign is_stop  = (bus.rx_data == KEY_STOP);
  assign is_up    = (bus.rx_data == KEY_UP);
  assign is_down  = (bus.rx_data == KEY_DOWN);
  assign len_half = note_len_q >> 1;

  always_comb begin
    note_len_d = note_len_q;
    if (accept && is_up) begin
      note_len_d = note_len_q[LEN_WIDTH-1] ? '1 : {note_len_q[LEN_WIDTH-2:0], 1'b0};
    end else if (accept && is_down) begin
      note_len_d = (len_half == '0) ? LEN_WIDTH'(1) : len_half;
    end
  end

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = (key_hit || is_stop || is_up || is_down) ? bus.rx_data : ECHO_UNKNOWN;
    end else if (tx_valid_q && bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      note_len_q <= LEN_WIDTH'(NOTE_LEN_INIT);
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      note_len_q <= note_len_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Note FSM; counter holds remaining sounding cycles minus one
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      fcw_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && key_hit) begin
            state_q   <= ST_PLAY;
            fcw_q     <= key_fcw;
            counter_q <= note_len_q - LEN_WIDTH'(1);
          end
        end
        ST_PLAY: begin
          if (accept && key_hit) begin
            fcw_q     <= key_fcw;
            counter_q <= note_len_q - LEN_WIDTH'(1);
          end else if (accept && is_stop) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
          end else if (counter_q == '0) begin
            state_q   <= ST_IDLE;
          end else begin
            counter_q <= counter_q - LEN_WIDTH'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          counter_q <= '0;
        end
      endcase
    end
  end

  assign bus.rx_ready = rx_ready;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.fcw      = fcw_q;
  assign bus.note_en  = (state_q == ST_PLAY);

endmodule
